// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - load/store unit shared constants, state encoding and command check
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  // funct3[1:0] encodes the access size for every legal code (00 byte, 01 half, 10 word)
  function automatic logic cmd_ok(input logic is_store, input logic [2:0] f3,
                                  input logic [1:0] off);
    logic legal;
    logic aligned;
    if (is_store)
      legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else
      legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
              (f3 == F3_LBU) || (f3 == F3_LHU);
    case (f3[1:0])
      2'd1:    aligned = !off[0];
      2'd2:    aligned = (off == 2'd0);
      default: aligned = 1'b1;
    endcase
    return legal && aligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load lane extraction/extension and sub-word store merge
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [15:0] store_data,
  output logic [31:0] load_value,
  output logic [31:0] merged_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_LB:   load_value = {{24{lane_b[7]}}, lane_b};
      F3_LH:   load_value = {{16{lane_h[15]}}, lane_h};
      F3_LBU:  load_value = {24'd0, lane_b};
      F3_LHU:  load_value = {16'd0, lane_h};
      default: load_value = word;
    endcase

    merged_word = word;
    case (funct3)
      F3_SB: merged_word[{offset, 3'b000} +: 8] = store_data[7:0];
      F3_SH: begin
        if (offset[1])
          merged_word[31:16] = store_data;
        else
          merged_word[15:0] = store_data;
      end
      default: merged_word = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multicycle load/store FSM with read-modify-write sub-word stores
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic [31:0]           load_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack
);

  lsu_state_t  state;
  logic        cmd_store;
  logic [2:0]  cmd_funct3;
  logic [1:0]  cmd_off;
  logic [15:0] cmd_data;
  logic [31:0] align_load;
  logic [31:0] align_merged;

  lsu_align u_align (
    .word        (mem_rdata),
    .offset      (cmd_off),
    .funct3      (cmd_funct3),
    .store_data  (cmd_data),
    .load_value  (align_load),
    .merged_word (align_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      load_data  <= 32'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      cmd_store  <= 1'b0;
      cmd_funct3 <= 3'd0;
      cmd_off    <= 2'd0;
      cmd_data   <= 16'd0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cmd_store  <= is_store;
            cmd_funct3 <= funct3;
            cmd_off    <= addr[1:0];
            cmd_data   <= store_data[15:0];
            busy       <= 1'b1;
            if (!cmd_ok(is_store, funct3, addr[1:0])) begin
              state <= ST_RESP;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              mem_addr <= {addr[ADDR_WIDTH-1:2], 2'b00};
              mem_req  <= 1'b1;
              if (is_store && funct3 == F3_SW) begin
                state     <= ST_WRITE;
                mem_we    <= 1'b1;
                mem_wdata <= store_data;
              end else begin
                state  <= ST_READ;
                mem_we <= 1'b0;
              end
            end
          end
        end
        // mem_req stays high across the read-to-write hop of an RMW
        ST_READ: begin
          if (mem_ack) begin
            if (cmd_store) begin
              state     <= ST_WRITE;
              mem_we    <= 1'b1;
              mem_wdata <= align_merged;
            end else begin
              state     <= ST_RESP;
              mem_req   <= 1'b0;
              load_data <= align_load;
              done      <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            state   <= ST_RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int total = 0;
  int bad   = 0;

  // memory model: ack after ack_delay wait cycles of a request phase
  logic [31:0] mem [0:255];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  int          wr_count  = 0;
  int          req_cnt   = 0;
  int          done_cnt  = 0;
  int          stable_err = 0;
  logic [31:0] last_wa = 0;
  logic [31:0] last_wd = 0;
  logic        pl_en = 0;
  logic [31:0] pl_addr = 0;
  logic [31:0] pl_data = 0;
  logic        prev_req = 0;
  logic        prev_ack = 0;
  logic        prev_we = 0;
  logic [31:0] prev_addr = 0;
  logic [31:0] prev_wdata = 0;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .load_data  (load_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr[9:2]] <= pl_data;
    if (mem_req && mem_ack && mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      wr_count <= wr_count + 1;
      last_wa  <= mem_addr;
      last_wd  <= mem_wdata;
    end
    if (mem_req) req_cnt <= req_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (mem_req && prev_req && !prev_ack &&
        (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata))
      stable_err <= stable_err + 1;
    prev_req   <= mem_req;
    prev_ack   <= mem_ack;
    prev_we    <= mem_we;
    prev_addr  <= mem_addr;
    prev_wdata <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // drives the command in cycle 0 and returns in cycle 1
  task automatic go(input logic st, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] d);
    start = 1'b1;
    is_store = st;
    funct3 = f3;
    addr = a;
    store_data = d;
    tick();
    start = 1'b0;
  endtask

  int snap_req;
  int snap_wr;
  int snap_done;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    is_store = 1'b0;
    funct3 = 3'd0;
    addr = 32'd0;
    store_data = 32'd0;
    preload(32'h100, 32'h80FF_1234);
    preload(32'h200, 32'h1122_3344);
    preload(32'h204, 32'h1122_3344);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_load", load_data, 0);
    rst = 1'b0;
    tick();

    // LB 0x103 over 0x80FF1234
    ack_delay = 0;
    go(1'b0, 3'd0, 32'h103, 32'd0);
    check("lb_req", mem_req, 1);
    check("lb_we", mem_we, 0);
    check("lb_addr", mem_addr, 32'h100);
    check("lb_busy", busy, 1);
    check("lb_done_c1", done, 0);
    tick();
    check("lb_done", done, 1);
    check("lb_fault", fault, 0);
    check("lb_data", load_data, 32'hFFFF_FF80);
    check("lb_req_off", mem_req, 0);
    tick();
    check("lb_idle", busy, 0);

    // LHU / LH 0x102 over 0x80017FFF
    preload(32'h100, 32'h8001_7FFF);
    go(1'b0, 3'd5, 32'h102, 32'd0);
    tick();
    check("lhu_done", done, 1);
    check("lhu_data", load_data, 32'h0000_8001);
    tick();
    go(1'b0, 3'd1, 32'h102, 32'd0);
    tick();
    check("lh_done", done, 1);
    check("lh_data", load_data, 32'hFFFF_8001);
    tick();
    check("lh_hold", load_data, 32'hFFFF_8001);

    // SB 0xAB at 0x201 with one wait cycle per phase
    ack_delay = 1;
    snap_wr = wr_count;
    go(1'b1, 3'd0, 32'h201, 32'h0000_00AB);
    check("sb_c1_req", mem_req, 1);
    check("sb_c1_we", mem_we, 0);
    check("sb_c1_addr", mem_addr, 32'h200);
    tick();
    check("sb_c2_req", mem_req, 1);
    check("sb_c2_we", mem_we, 0);
    tick();
    check("sb_c3_req", mem_req, 1);
    check("sb_c3_we", mem_we, 1);
    check("sb_c3_wdata", mem_wdata, 32'h1122_AB44);
    check("sb_c3_addr", mem_addr, 32'h200);
    tick();
    check("sb_c4_req", mem_req, 1);
    check("sb_c4_done", done, 0);
    tick();
    check("sb_c5_done", done, 1);
    check("sb_c5_fault", fault, 0);
    check("sb_c5_req", mem_req, 0);
    check("sb_wr_count", wr_count - snap_wr, 1);
    check("sb_wr_addr", last_wa, 32'h200);
    check("sb_wr_data", last_wd, 32'h1122_AB44);
    check("sb_load_held", load_data, 32'hFFFF_8001);
    tick();

    // SH 0xBEEF at 0x206, ack in request cycle
    ack_delay = 0;
    go(1'b1, 3'd1, 32'h206, 32'h1234_BEEF);
    tick();
    check("sh_rmw_req", mem_req, 1);
    check("sh_rmw_we", mem_we, 1);
    tick();
    check("sh_done", done, 1);
    check("sh_wr_data", last_wd, 32'hBEEF_3344);
    check("sh_wr_addr", last_wa, 32'h204);
    tick();

    // SW 0x300
    go(1'b1, 3'd2, 32'h300, 32'hCAFE_F00D);
    check("sw_we", mem_we, 1);
    check("sw_wdata", mem_wdata, 32'hCAFE_F00D);
    tick();
    check("sw_done", done, 1);
    check("sw_wr_data", last_wd, 32'hCAFE_F00D);
    tick();

    // faults: misaligned SW, illegal load funct3, misaligned LH
    snap_req = req_cnt;
    go(1'b1, 3'd2, 32'h302, 32'h1);
    check("swmis_done", done, 1);
    check("swmis_fault", fault, 1);
    check("swmis_busy", busy, 1);
    check("swmis_req", mem_req, 0);
    tick();
    check("swmis_done_c2", done, 0);
    check("swmis_idle", busy, 0);
    go(1'b0, 3'd3, 32'h100, 32'd0);
    check("f3bad_done", done, 1);
    check("f3bad_fault", fault, 1);
    tick();
    go(1'b0, 3'd1, 32'h101, 32'd0);
    check("lhmis_fault", fault, 1);
    tick();
    check("fault_no_req", req_cnt - snap_req, 0);
    check("fault_load_held", load_data, 32'hFFFF_8001);

    // LW with a second start while busy
    ack_delay = 2;
    snap_wr = wr_count;
    snap_done = done_cnt;
    go(1'b0, 3'd2, 32'h100, 32'd0);
    start = 1'b1;
    is_store = 1'b1;
    funct3 = 3'd2;
    addr = 32'h300;
    store_data = 32'h5555_5555;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("lw_done", done, 1);
    check("lw_data", load_data, 32'h8001_7FFF);
    for (int i = 0; i < 4; i++) tick();
    check("lw_one_done", done_cnt - snap_done, 1);
    check("lw_no_write", wr_count - snap_wr, 0);
    check("addr_stable", stable_err, 0);

    // reset while in WRITE of an RMW
    ack_delay = 1;
    snap_wr = wr_count;
    go(1'b1, 3'd0, 32'h203, 32'h55);
    tick();
    tick();
    check("rstw_we", mem_we, 1);
    rst = 1'b1;
    #1;
    check("rstw_req", mem_req, 0);
    check("rstw_busy", busy, 0);
    check("rstw_we0", mem_we, 0);
    check("rstw_load", load_data, 0);
    tick();
    rst = 1'b0;
    tick();
    check("rstw_no_write", wr_count - snap_wr, 0);
    check("rstw_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
